// File: rtl/axi_lite_cmd_master_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axi_lite_cmd_master_if                                                   |
// | AXI4-Lite bus bundle between the command master and a register slave.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface axi_lite_cmd_master_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   m_awaddr;
  logic [2:0]              m_awprot;
  logic                    m_awvalid;
  logic                    m_awready;
  logic [DATA_WIDTH-1:0]   m_wdata;
  logic [DATA_WIDTH/8-1:0] m_wstrb;
  logic                    m_wvalid;
  logic                    m_wready;
  logic [1:0]              m_bresp;
  logic                    m_bvalid;
  logic                    m_bready;
  logic [ADDR_WIDTH-1:0]   m_araddr;
  logic [2:0]              m_arprot;
  logic                    m_arvalid;
  logic                    m_arready;
  logic [DATA_WIDTH-1:0]   m_rdata;
  logic [1:0]              m_rresp;
  logic                    m_rvalid;
  logic                    m_rready;

  modport master (
    output m_awaddr, m_awprot, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready,
           m_araddr, m_arprot, m_arvalid, m_rready,
    input  m_awready, m_wready, m_bresp, m_bvalid, m_arready, m_rdata, m_rresp, m_rvalid
  );

  modport slave (
    input  m_awaddr, m_awprot, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready,
           m_araddr, m_arprot, m_arvalid, m_rready,
    output m_awready, m_wready, m_bresp, m_bvalid, m_arready, m_rdata, m_rresp, m_rvalid
  );
endinterface
`default_nettype wire

// File: rtl/axi_lite_cmd_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axi_lite_cmd_master                                                      |
// | Queued read/write commands in, one AXI4-Lite transaction at a time out.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module axi_lite_cmd_master #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int CMD_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  wire                      axi_aclk,
  input  wire                      axi_areset,
  input  wire                      cmd_valid,
  output logic                     cmd_ready,
  input  wire                      cmd_we,
  input  wire [ADDR_WIDTH-1:0]     cmd_addr,
  input  wire [DATA_WIDTH-1:0]     cmd_wdata,
  input  wire [DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                     rsp_valid,
  input  wire                      rsp_ready,
  output logic                     rsp_is_write,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic [1:0]               rsp_resp,
  output logic                     busy,
  output logic                     timeout_flag,
  axi_lite_cmd_master_if.master    m
);
  localparam int c_STRB_W = DATA_WIDTH / 8;
  localparam int c_IDX_W  = $clog2(CMD_DEPTH);
  localparam int c_PTR_W  = c_IDX_W + 1;
  localparam int c_TO_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_WR_ADDR_DATA = 3'd1,
    S_WR_RESP      = 3'd2,
    S_RD_ADDR      = 3'd3,
    S_RD_DATA      = 3'd4,
    S_RSP          = 3'd5
  } state_t;

  // Command FIFO; pointers carry an extra wrap bit to tell full from empty.
  logic                  r_fifo_we    [CMD_DEPTH];
  logic [ADDR_WIDTH-1:0] r_fifo_addr  [CMD_DEPTH];
  logic [DATA_WIDTH-1:0] r_fifo_wdata [CMD_DEPTH];
  logic [c_STRB_W-1:0]   r_fifo_wstrb [CMD_DEPTH];
  logic [c_PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
  logic [c_IDX_W-1:0]    w_wr_idx, w_rd_idx;
  logic                  w_full, w_empty, w_push, w_pop;

  assign w_wr_idx  = r_wr_ptr[c_IDX_W-1:0];
  assign w_rd_idx  = r_rd_ptr[c_IDX_W-1:0];
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[c_IDX_W] != r_rd_ptr[c_IDX_W]) && (w_wr_idx == w_rd_idx);
  assign w_push    = cmd_valid && !w_full;
  assign cmd_ready = !w_full;

  always_ff @(posedge axi_aclk) begin
    if (w_push) begin
      r_fifo_we[w_wr_idx]    <= cmd_we;
      r_fifo_addr[w_wr_idx]  <= cmd_addr;
      r_fifo_wdata[w_wr_idx] <= cmd_wdata;
      r_fifo_wstrb[w_wr_idx] <= cmd_wstrb;
    end
  end

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
    end
  end

  // Every bus-facing and response output is a flop; *_nxt is its D input.
  state_t                r_state, w_state_nxt;
  logic                  r_awvalid, w_awvalid_nxt;
  logic                  r_wvalid, w_wvalid_nxt;
  logic                  r_bready, w_bready_nxt;
  logic                  r_arvalid, w_arvalid_nxt;
  logic                  r_rready, w_rready_nxt;
  logic                  r_aw_done, w_aw_done_nxt;
  logic                  r_w_done, w_w_done_nxt;
  logic [ADDR_WIDTH-1:0] r_awaddr, w_awaddr_nxt;
  logic [ADDR_WIDTH-1:0] r_araddr, w_araddr_nxt;
  logic [DATA_WIDTH-1:0] r_wdata, w_wdata_nxt;
  logic [c_STRB_W-1:0]   r_wstrb, w_wstrb_nxt;
  logic                  r_rsp_valid, w_rsp_valid_nxt;
  logic                  r_rsp_is_write, w_rsp_is_write_nxt;
  logic [DATA_WIDTH-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
  logic [1:0]            r_rsp_resp, w_rsp_resp_nxt;
  logic                  w_aw_hs, w_w_hs;

  assign w_aw_hs = r_awvalid && m.m_awready;
  assign w_w_hs  = r_wvalid && m.m_wready;

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      r_state        <= S_IDLE;
      r_awvalid      <= 1'b0;
      r_wvalid       <= 1'b0;
      r_bready       <= 1'b0;
      r_arvalid      <= 1'b0;
      r_rready       <= 1'b0;
      r_aw_done      <= 1'b0;
      r_w_done       <= 1'b0;
      r_awaddr       <= '0;
      r_araddr       <= '0;
      r_wdata        <= '0;
      r_wstrb        <= '0;
      r_rsp_valid    <= 1'b0;
      r_rsp_is_write <= 1'b0;
      r_rsp_rdata    <= '0;
      r_rsp_resp     <= 2'b00;
    end else begin
      r_state        <= w_state_nxt;
      r_awvalid      <= w_awvalid_nxt;
      r_wvalid       <= w_wvalid_nxt;
      r_bready       <= w_bready_nxt;
      r_arvalid      <= w_arvalid_nxt;
      r_rready       <= w_rready_nxt;
      r_aw_done      <= w_aw_done_nxt;
      r_w_done       <= w_w_done_nxt;
      r_awaddr       <= w_awaddr_nxt;
      r_araddr       <= w_araddr_nxt;
      r_wdata        <= w_wdata_nxt;
      r_wstrb        <= w_wstrb_nxt;
      r_rsp_valid    <= w_rsp_valid_nxt;
      r_rsp_is_write <= w_rsp_is_write_nxt;
      r_rsp_rdata    <= w_rsp_rdata_nxt;
      r_rsp_resp     <= w_rsp_resp_nxt;
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_pop              = 1'b0;
    w_awvalid_nxt      = r_awvalid;
    w_wvalid_nxt       = r_wvalid;
    w_bready_nxt       = r_bready;
    w_arvalid_nxt      = r_arvalid;
    w_rready_nxt       = r_rready;
    w_aw_done_nxt      = r_aw_done;
    w_w_done_nxt       = r_w_done;
    w_awaddr_nxt       = r_awaddr;
    w_araddr_nxt       = r_araddr;
    w_wdata_nxt        = r_wdata;
    w_wstrb_nxt        = r_wstrb;
    w_rsp_valid_nxt    = r_rsp_valid;
    w_rsp_is_write_nxt = r_rsp_is_write;
    w_rsp_rdata_nxt    = r_rsp_rdata;
    w_rsp_resp_nxt     = r_rsp_resp;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (r_fifo_we[w_rd_idx]) begin
            w_state_nxt   = S_WR_ADDR_DATA;
            w_awvalid_nxt = 1'b1;
            w_wvalid_nxt  = 1'b1;
            w_aw_done_nxt = 1'b0;
            w_w_done_nxt  = 1'b0;
            w_awaddr_nxt  = r_fifo_addr[w_rd_idx];
            w_wdata_nxt   = r_fifo_wdata[w_rd_idx];
            w_wstrb_nxt   = r_fifo_wstrb[w_rd_idx];
          end else begin
            w_state_nxt   = S_RD_ADDR;
            w_arvalid_nxt = 1'b1;
            w_araddr_nxt  = r_fifo_addr[w_rd_idx];
          end
        end
      end
      S_WR_ADDR_DATA: begin
        // AW and W complete independently and in either order.
        if (w_aw_hs) begin
          w_awvalid_nxt = 1'b0;
          w_aw_done_nxt = 1'b1;
        end
        if (w_w_hs) begin
          w_wvalid_nxt = 1'b0;
          w_w_done_nxt = 1'b1;
        end
        if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
          w_state_nxt  = S_WR_RESP;
          w_bready_nxt = 1'b1;
        end
      end
      S_WR_RESP: begin
        if (m.m_bvalid) begin
          w_bready_nxt       = 1'b0;
          w_rsp_valid_nxt    = 1'b1;
          w_rsp_is_write_nxt = 1'b1;
          w_rsp_rdata_nxt    = '0;
          w_rsp_resp_nxt     = m.m_bresp;
          w_state_nxt        = S_RSP;
        end
      end
      S_RD_ADDR: begin
        if (r_arvalid && m.m_arready) begin
          w_arvalid_nxt = 1'b0;
          w_rready_nxt  = 1'b1;
          w_state_nxt   = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (m.m_rvalid) begin
          w_rready_nxt       = 1'b0;
          w_rsp_valid_nxt    = 1'b1;
          w_rsp_is_write_nxt = 1'b0;
          w_rsp_rdata_nxt    = m.m_rdata;
          w_rsp_resp_nxt     = m.m_rresp;
          w_state_nxt        = S_RSP;
        end
      end
      S_RSP: begin
        if (rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_timeout
      localparam logic [c_TO_W-1:0] c_TO_MAX = c_TO_W'(TIMEOUT_CYCLES);
      localparam logic [c_TO_W-1:0] c_TO_ONE = c_TO_W'(1);
      logic [c_TO_W-1:0] r_to_cnt, w_to_cnt_nxt;
      logic              r_to_flag;
      logic              w_in_axi;

      assign w_in_axi = (r_state == S_WR_ADDR_DATA) || (r_state == S_WR_RESP) ||
                        (r_state == S_RD_ADDR)      || (r_state == S_RD_DATA);

      // Restarts on every state change; saturates so the flag cannot re-arm.
      always_comb begin
        w_to_cnt_nxt = r_to_cnt;
        if (w_state_nxt != r_state) begin
          w_to_cnt_nxt = '0;
        end else if (w_in_axi && (r_to_cnt != c_TO_MAX)) begin
          w_to_cnt_nxt = r_to_cnt + c_TO_ONE;
        end
      end

      always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
          r_to_cnt  <= '0;
          r_to_flag <= 1'b0;
        end else begin
          r_to_cnt <= w_to_cnt_nxt;
          if (w_to_cnt_nxt == c_TO_MAX) r_to_flag <= 1'b1;
        end
      end

      assign timeout_flag = r_to_flag;
    end else begin : g_no_timeout
      assign timeout_flag = 1'b0;
    end
  endgenerate

  assign busy         = !w_empty || (r_state != S_IDLE);
  assign rsp_valid    = r_rsp_valid;
  assign rsp_is_write = r_rsp_is_write;
  assign rsp_rdata    = r_rsp_rdata;
  assign rsp_resp     = r_rsp_resp;

  assign m.m_awaddr  = r_awaddr;
  assign m.m_awprot  = 3'b000;
  assign m.m_awvalid = r_awvalid;
  assign m.m_wdata   = r_wdata;
  assign m.m_wstrb   = r_wstrb;
  assign m.m_wvalid  = r_wvalid;
  assign m.m_bready  = r_bready;
  assign m.m_araddr  = r_araddr;
  assign m.m_arprot  = 3'b000;
  assign m.m_arvalid = r_arvalid;
  assign m.m_rready  = r_rready;
endmodule
`default_nettype wire
